// File: rtl/mem_bus_arbiter.sv
// Two-master arbiter sharing one memory-map decoder port: M0 (load/store) and M1 (fetch, read-only).
// Fixed-priority for M0 with an anti-starvation limit; each access is a fixed-length bus cycle.
module mem_bus_arbiter #(
  parameter int RD_LATENCY = 1,
  parameter int MAX_CONSEC = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        m0_req,
  input  logic        m0_we,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  output logic        m0_ready,
  output logic [31:0] m0_rdata,
  input  logic        m1_req,
  input  logic [31:0] m1_addr,
  output logic        m1_ready,
  output logic [31:0] m1_rdata,
  output logic        bus_mem_read,
  output logic        bus_mem_write,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata,
  output logic        bus_owner,
  output logic        busy,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_WAIT   = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  localparam logic [3:0] CONSEC_LIMIT = 4'(MAX_CONSEC);
  localparam logic [1:0] WAIT_LAST    = 2'((RD_LATENCY > 0) ? RD_LATENCY - 1 : 0);

  state_t      r_state;
  logic        r_owner;
  logic        r_we;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [3:0]  r_consec;
  logic [1:0]  r_wait_cnt;
  logic [31:0] r_m0_rdata;
  logic [31:0] r_m1_rdata;
  logic        w_pick_m1;

  // M1 only wins a tie once M0 has used up its run of consecutive grants.
  assign w_pick_m1 = m1_req && (!m0_req || (r_consec == CONSEC_LIMIT));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_owner    <= 1'b0;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_consec   <= '0;
      r_wait_cnt <= '0;
      r_m0_rdata <= '0;
      r_m1_rdata <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (m0_req || m1_req) begin
            r_state <= S_ACCESS;
            r_owner <= w_pick_m1;
            if (w_pick_m1) begin
              r_we     <= 1'b0;
              r_addr   <= m1_addr;
              r_consec <= '0;
            end else begin
              r_we    <= m0_we;
              r_addr  <= m0_addr;
              r_wdata <= m0_wdata;
              if (!m1_req)
                r_consec <= '0;
              else if (r_consec != CONSEC_LIMIT)
                r_consec <= r_consec + 4'd1;
            end
          end
        end
        S_ACCESS: begin
          if (r_we) begin
            r_state <= S_DONE;
          end else if (RD_LATENCY > 0) begin
            r_state    <= S_WAIT;
            r_wait_cnt <= '0;
          end else begin
            r_state <= S_DONE;
            if (r_owner) r_m1_rdata <= bus_rdata;
            else         r_m0_rdata <= bus_rdata;
          end
        end
        S_WAIT: begin
          if (r_wait_cnt == WAIT_LAST) begin
            r_state <= S_DONE;
            if (r_owner) r_m1_rdata <= bus_rdata;
            else         r_m0_rdata <= bus_rdata;
          end else begin
            r_wait_cnt <= r_wait_cnt + 2'd1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus_mem_read  = ((r_state == S_ACCESS) || (r_state == S_WAIT)) && !r_we;
  assign bus_mem_write = (r_state == S_ACCESS) && r_we;
  assign bus_addr      = r_addr;
  assign bus_wdata     = r_wdata;
  assign bus_owner     = r_owner;
  assign m0_ready      = (r_state == S_DONE) && !r_owner;
  assign m1_ready      = (r_state == S_DONE) && r_owner;
  assign m0_rdata      = r_m0_rdata;
  assign m1_rdata      = r_m1_rdata;
  assign busy          = (r_state != S_IDLE);
  assign dbg_state     = r_state;

endmodule

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

- Shares the single memory-map decoder port between two masters:
  - M0: data load/store unit.
  - M1: instruction fetch unit, read-only.
- Sits between the multi-cycle RISC-V core and the memory map decoder. Drives its MemRead/MemWrite/address/write-data inputs and captures its read-data output.
- Sequences each access as a fixed-length bus cycle that allows for synchronous device read latency.
- Arbitration is fixed-priority with an anti-starvation limit.

## Interface

Parameters:
- RD_LATENCY, 1: extra cycles the bus is held before read data is captured; legal range 0..3.
- MAX_CONSEC, 4: maximum back-to-back M0 grants while M1 is pending; legal range 1..15.

Ports:
- clk  in  1  system clock, rising-edge.
- rst  in  1  synchronous, active-high reset.
- m0_req  in  1  M0 access request; held stable until m0_ready.
- m0_we  in  1  M0 write enable (1 = store, 0 = load).
- m0_addr  in  32  M0 byte address.
- m0_wdata  in  32  M0 store data.
- m0_ready  out  1  one-cycle completion pulse to M0.
- m0_rdata  out  32  M0 load data; valid with m0_ready, held until next M0 read.
- m1_req  in  1  fetch request; held stable until m1_ready.
- m1_addr  in  32  fetch byte address.
- m1_ready  out  1  one-cycle completion pulse to M1.
- m1_rdata  out  32  fetched instruction; valid with m1_ready, held until next M1 read.
- bus_mem_read  out  1  to decoder MemRead.
- bus_mem_write  out  1  to decoder MemWrite.
- bus_addr  out  32  to decoder AddrIn.
- bus_wdata  out  32  to decoder DataIn.
- bus_rdata  in  32  from decoder DataOut.
- bus_owner  out  1  owner of the current or last transaction (0 = M0, 1 = M1).
- busy  out  1  high in every state except IDLE.

## Operation

- States:
  - IDLE
  - ACCESS
  - WAIT
  - DONE
- All outputs are registered or decoded only from registers; there are no combinational paths from inputs to outputs.
- IDLE:
  - Requests are sampled at the clock edge ending the IDLE cycle.
  - If any request is present: latch winner, we, addr and wdata, then go to ACCESS.
  - With no request, stay in IDLE.
- Arbitration:
  - M0 wins if both masters request, unless consec_cnt == MAX_CONSEC, in which case M1 wins.
  - consec_cnt increments on an M0 grant while m1_req = 1.
  - consec_cnt clears on an M1 grant, or on an M0 grant with m1_req = 0.
  - consec_cnt saturates at MAX_CONSEC.
- Any M1 grant forces the write enable to 0. m0_we has no meaning for M1.
- ACCESS (1 cycle):
  - bus_addr and bus_wdata carry the latched values.
  - bus_mem_read = !we; bus_mem_write = we.
  - A write goes to DONE.
  - A read goes to WAIT if RD_LATENCY > 0. Otherwise it captures bus_rdata into the owner's rdata register and goes to DONE.
- WAIT (RD_LATENCY cycles):
  - Strobes and address are held.
  - A 2-bit counter runs; bus_rdata is captured at the edge ending the last WAIT cycle.
  - Then go to DONE.
- DONE (1 cycle):
  - The owner's ready is 1; bus strobes are 0.
  - Unconditionally return to IDLE.
- Master rule:
  - A master that wants no further access must deassert req by the IDLE cycle following its ready.
  - A req still high at the end of that IDLE cycle is a new transaction.
- The non-owner's rdata register is never modified.

## Timing

- Reset values:
  - State is IDLE, consec_cnt is 0.
  - All outputs are 0: ready, rdata, bus strobes, bus_addr, bus_wdata, bus_owner, busy.
- Latency from req sampled to ready high:
  - Write or RD_LATENCY = 0 read: 2 cycles (ACCESS, then DONE).
  - Read: 2 + RD_LATENCY cycles.
- Throughput: one transaction per 3 + RD_LATENCY cycles, due to the mandatory IDLE gap.
- bus_addr and bus_wdata hold their last values while in IDLE and DONE. The strobes are 0 there.
- Simultaneous requests in IDLE are resolved only by the arbitration rule. A request arriving during a transaction waits for IDLE.
- Reset mid-operation:
  - The next edge forces IDLE and clears strobes, ready and rdata.
  - The in-flight transaction is abandoned with no ready pulse. A write whose ACCESS cycle has already occurred stays committed.
- A req that drops before ready is a protocol violation. The transaction still completes on the latched values.

## Test plan

- Reset check: rst = 1 for 2 cycles, then 0 with no req -> all outputs 0, busy = 0, state stays IDLE.
- M0 store, RD_LATENCY = 1:
  - Stimulus: addr 0x1001_0004, wdata 0xDEAD_BEEF.
  - Required response: bus_mem_write = 1 for exactly 1 cycle with bus_addr 0x1001_0004 and bus_wdata 0xDEAD_BEEF.
  - m0_ready pulses 2 cycles after the sample edge.
- M1 fetch, RD_LATENCY = 2:
  - Stimulus: addr 0x0040_0000, bus_rdata model returns 0x0000_0013.
  - Required response: bus_mem_read = 1 for 3 cycles; m1_ready after 4 cycles with m1_rdata = 0x0000_0013.
  - m0_rdata is unchanged.
- Contention, MAX_CONSEC = 4: m0_req and m1_req both held continuously -> grant order M0, M0, M0, M0, M1, M0, ...
- M1 with m0_we = 1 present: an M1 grant never asserts bus_mem_write.
- Reset mid-WAIT: rst asserted in WAIT -> next cycle shows IDLE, strobes 0, no ready pulse. A fresh M0 read afterwards completes normally.
